// File: rtl/cpu_boot_driver.sv
// cpu_boot_driver: preloads init words into data memory, runs the core,
// collects mailbox result bits. Optional watchdog: CPU_BOOT_DRIVER_TIMEOUT_EN.
module cpu_boot_driver #(
    parameter int          INIT_WORDS     = 2,
    parameter logic [31:0] INIT_BASE      = 32'h0200_0000,
    parameter int          ADR_STRIDE     = 4,
    parameter logic [31:0] MAILBOX_ADR    = 32'h0200_0000,
    parameter int          OUT_WIDTH      = 8,
    parameter int          TIMEOUT_CYCLES = 4096,
    localparam int         IDX_W          = $clog2(OUT_WIDTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    CPU_start,
    input  logic [32*INIT_WORDS-1:0] init_data,
    input  logic                    MemWrite,
    input  logic [31:0]             WriteData,
    input  logic [31:0]             DataAdr,
    output logic                    cpu_reset,
    output logic                    Ext_MemWrite,
    output logic [31:0]             Ext_WriteData,
    output logic [31:0]             Ext_DataAdr,
    output logic [OUT_WIDTH-1:0]    final_output,
    output logic [IDX_W-1:0]        out_index,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout
);

    typedef enum logic [2:0] {
        IDLE,
        INIT_WR,
        INIT_GAP,
        RUN,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  word_cnt;
    logic        start_q;
    logic        start_edge;
    logic        start_ok;
    logic        capture;
    logic        last_word;
    logic        last_bit;
    logic [31:0] word_sel;
    logic [31:0] word_adr;

    assign start_edge = CPU_start && !start_q;
    assign start_ok   = start_edge &&
                        (state == IDLE || state == RUN || state == DONE);
    assign capture    = MemWrite && (DataAdr == MAILBOX_ADR);
    assign last_word  = (word_cnt == 4'(INIT_WORDS - 1));
    assign last_bit   = (out_index == IDX_W'(OUT_WIDTH - 1));
    assign word_adr   = INIT_BASE + 32'(word_cnt) * 32'(ADR_STRIDE);

    // Select the init word addressed by the word counter.
    always_comb begin
        word_sel = '0;
        for (int i = 0; i < INIT_WORDS; i++) begin
            if (word_cnt == 4'(i)) begin
                word_sel = init_data[32*i +: 32];
            end
        end
    end

`ifdef CPU_BOOT_DRIVER_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        wd_expire;
    logic        unused_bits;

    assign wd_expire   = (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign unused_bits = ^WriteData[31:1];
`else
    logic unused_bits;

    // No watchdog in this build: RUN waits for the program indefinitely.
    assign timeout     = 1'b0;
    assign unused_bits = ^{WriteData[31:1], 32'(TIMEOUT_CYCLES)};
`endif

    // Boot sequencer: start detect, preload, run, result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cpu_reset     <= 1'b1;
            Ext_MemWrite  <= 1'b0;
            Ext_WriteData <= '0;
            Ext_DataAdr   <= '0;
            final_output  <= '0;
            out_index     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            word_cnt      <= '0;
            start_q       <= 1'b0;
`ifdef CPU_BOOT_DRIVER_TIMEOUT_EN
            timeout       <= 1'b0;
            wd_cnt        <= '0;
`endif
        end else begin
            start_q <= CPU_start;
            if (start_ok) begin
                // A new start wins over any capture in the same cycle.
                state         <= INIT_WR;
                cpu_reset     <= 1'b1;
                Ext_MemWrite  <= 1'b0;
                Ext_WriteData <= '0;
                Ext_DataAdr   <= '0;
                final_output  <= '0;
                out_index     <= '0;
                busy          <= 1'b1;
                done          <= 1'b0;
                word_cnt      <= '0;
`ifdef CPU_BOOT_DRIVER_TIMEOUT_EN
                timeout       <= 1'b0;
                wd_cnt        <= '0;
`endif
            end else begin
                unique case (state)
                    IDLE: begin
                        cpu_reset <= 1'b1;
                    end
                    INIT_WR: begin
                        cpu_reset     <= 1'b1;
                        Ext_MemWrite  <= 1'b1;
                        Ext_WriteData <= word_sel;
                        Ext_DataAdr   <= word_adr;
                        state         <= INIT_GAP;
                    end
                    INIT_GAP: begin
                        Ext_MemWrite  <= 1'b0;
                        Ext_WriteData <= '0;
                        Ext_DataAdr   <= '0;
                        if (last_word) begin
                            state     <= RUN;
                            cpu_reset <= 1'b0;
`ifdef CPU_BOOT_DRIVER_TIMEOUT_EN
                            wd_cnt    <= '0;
`endif
                        end else begin
                            word_cnt  <= word_cnt + 4'd1;
                            state     <= INIT_WR;
                        end
                    end
                    RUN: begin
                        if (capture) begin
                            for (int i = 0; i < OUT_WIDTH; i++) begin
                                if (out_index == IDX_W'(i)) begin
                                    final_output[i] <= WriteData[0];
                                end
                            end
                            out_index <= out_index + IDX_W'(1);
`ifdef CPU_BOOT_DRIVER_TIMEOUT_EN
                            wd_cnt    <= '0;
`endif
                            if (last_bit) begin
                                state     <= DONE;
                                cpu_reset <= 1'b1;
                                done      <= 1'b1;
                                busy      <= 1'b0;
                            end
                        end
`ifdef CPU_BOOT_DRIVER_TIMEOUT_EN
                        else if (wd_expire) begin
                            // Program went silent: stop it, keep partial bits.
                            state     <= DONE;
                            cpu_reset <= 1'b1;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            timeout   <= 1'b1;
                        end else begin
                            wd_cnt <= wd_cnt + 32'd1;
                        end
`endif
                    end
                    DONE: begin
                        cpu_reset <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_boot_driver.sv
// tb_cpu_boot_driver: directed bench for cpu_boot_driver.
// Default parameters except TIMEOUT_CYCLES=16.
module tb_cpu_boot_driver;

    logic        clk;
    logic        reset;
    logic        CPU_start;
    logic [63:0] init_data;
    logic        MemWrite;
    logic [31:0] WriteData;
    logic [31:0] DataAdr;
    logic        cpu_reset;
    logic        Ext_MemWrite;
    logic [31:0] Ext_WriteData;
    logic [31:0] Ext_DataAdr;
    logic [7:0]  final_output;
    logic [3:0]  out_index;
    logic        busy;
    logic        done;
    logic        timeout;

    int checks = 0;
    int errors = 0;
    int wr_cnt;

    cpu_boot_driver #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .CPU_start    (CPU_start),
        .init_data    (init_data),
        .MemWrite     (MemWrite),
        .WriteData    (WriteData),
        .DataAdr      (DataAdr),
        .cpu_reset    (cpu_reset),
        .Ext_MemWrite (Ext_MemWrite),
        .Ext_WriteData(Ext_WriteData),
        .Ext_DataAdr  (Ext_DataAdr),
        .final_output (final_output),
        .out_index    (out_index),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [31:0] adr, input logic bit0,
                         input logic we);
        MemWrite  = we;
        DataAdr   = adr;
        WriteData = {31'h1234_5678 >> 1, bit0};
        step();
        MemWrite  = 1'b0;
        WriteData = '0;
    endtask

    initial begin
        reset     = 1'b1;
        CPU_start = 1'b0;
        init_data = {32'h0000_00A5, 32'h0000_005A};
        MemWrite  = 1'b0;
        WriteData = '0;
        DataAdr   = '0;
        step();
        step();
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_ext_we", Ext_MemWrite, 0);
        check("rst_ext_data", Ext_WriteData, 0);
        check("rst_ext_adr", Ext_DataAdr, 0);
        check("rst_final", final_output, 0);
        check("rst_index", out_index, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        reset = 1'b0;
        step();

        // single start pulse, preload of two words
        CPU_start = 1'b1;
        step();
        CPU_start = 1'b0;
        check("t0_busy", busy, 1);
        check("t0_ext_we", Ext_MemWrite, 0);
        step();
        check("w0_we", Ext_MemWrite, 1);
        check("w0_data", Ext_WriteData, 32'h5A);
        check("w0_adr", Ext_DataAdr, 32'h0200_0000);
        check("w0_cpu_reset", cpu_reset, 1);
        step();
        check("g0_we", Ext_MemWrite, 0);
        check("g0_data", Ext_WriteData, 0);
        check("g0_adr", Ext_DataAdr, 0);
        step();
        check("w1_we", Ext_MemWrite, 1);
        check("w1_data", Ext_WriteData, 32'hA5);
        check("w1_adr", Ext_DataAdr, 32'h0200_0004);
        check("w1_cpu_reset", cpu_reset, 1);
        step();
        check("g1_we", Ext_MemWrite, 0);
        check("run_cpu_reset", cpu_reset, 0);
        check("run_busy", busy, 1);

        // mailbox captures 1,0,1 then ignored stores
        store(32'h0200_0000, 1'b1, 1'b1);
        check("cap0_final", final_output, 8'h01);
        check("cap0_index", out_index, 1);
        store(32'h0200_0000, 1'b0, 1'b1);
        store(32'h0200_0000, 1'b1, 1'b1);
        check("cap2_final", final_output, 8'h05);
        check("cap2_index", out_index, 3);
        store(32'h0200_0004, 1'b1, 1'b1);
        store(32'h0200_0000, 1'b1, 1'b0);
        check("ign_final", final_output, 8'h05);
        check("ign_index", out_index, 3);
        store(32'h0200_0000, 1'b1, 1'b1);
        store(32'h0200_0000, 1'b0, 1'b1);
        store(32'h0200_0000, 1'b0, 1'b1);
        store(32'h0200_0000, 1'b1, 1'b1);
        check("cap6_done", done, 0);
        check("cap6_index", out_index, 7);
        store(32'h0200_0000, 1'b0, 1'b1);
        check("fin_final", final_output, 8'h4D);
        check("fin_index", out_index, 8);
        check("fin_done", done, 1);
        check("fin_cpu_reset", cpu_reset, 1);
        check("fin_busy", busy, 0);
        store(32'h0200_0000, 1'b1, 1'b1);
        check("post_final", final_output, 8'h4D);
        check("post_index", out_index, 8);

        // CPU_start held high: exactly one preload
        CPU_start = 1'b1;
        wr_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (Ext_MemWrite) wr_cnt++;
        end
        check("hold_writes", wr_cnt, 2);
        check("hold_final", final_output, 0);
        check("hold_index", out_index, 0);
        check("hold_done", done, 0);
        check("hold_cpu_reset", cpu_reset, 0);
        for (int i = 0; i < 8; i++) begin
            store(32'h0200_0000, 1'b1, 1'b1);
        end
        check("ones_final", final_output, 8'hFF);
        check("ones_done", done, 1);

        // drop and re-raise from DONE, then reset mid-init
        CPU_start = 1'b0;
        step();
        CPU_start = 1'b1;
        step();
        check("re_final", final_output, 0);
        check("re_index", out_index, 0);
        check("re_done", done, 0);
        check("re_busy", busy, 1);
        step();
        check("re_w0_we", Ext_MemWrite, 1);
        check("re_w0_data", Ext_WriteData, 32'h5A);
        step();
        reset     = 1'b1;
        CPU_start = 1'b0;
        step();
        check("mid_rst_we", Ext_MemWrite, 0);
        check("mid_rst_cpu_reset", cpu_reset, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        reset = 1'b0;
        step();
        step();
        check("idle_we", Ext_MemWrite, 0);
        check("idle_busy", busy, 0);

        // three captures then silence
        CPU_start = 1'b1;
        step();
        CPU_start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("to_run", cpu_reset, 0);
        store(32'h0200_0000, 1'b1, 1'b1);
        store(32'h0200_0000, 1'b1, 1'b1);
        store(32'h0200_0000, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) step();
        check("to_pre_done", done, 0);
        check("to_pre_timeout", timeout, 0);
        step();
        check("to_index", out_index, 3);
        check("to_final", final_output, 8'h03);
`ifdef CPU_BOOT_DRIVER_TIMEOUT_EN
        check("to_timeout", timeout, 1);
        check("to_done", done, 1);
        check("to_cpu_reset", cpu_reset, 1);
        check("to_busy", busy, 0);
`else
        check("to_timeout", timeout, 0);
        check("to_done", done, 0);
        check("to_cpu_reset", cpu_reset, 0);
        check("to_busy", busy, 1);
        for (int i = 0; i < 40; i++) step();
        check("to_still_run", busy, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_boot_driver.md
# cpu_boot_driver

Parametrised successor to the single-shot CPU start driver. It holds the RISC-V core in reset and preloads a configurable list of 32-bit words into data memory over the external write port. It then releases the core and collects single-bit results that the program writes to a mailbox address into an OUT_WIDTH-bit output register. It sits between the top-level start control and the data-memory mux, alongside the CPU.

## Interface
Parameters:
- INIT_WORDS, 2: number of words preloaded per start (1..16).
- INIT_BASE, 32'h02000000: address of init word 0.
- ADR_STRIDE, 4: byte stride between init words.
- MAILBOX_ADR, 32'h02000000: CPU store address captured as a result bit.
- OUT_WIDTH, 8: number of result bits collected (1..64).
- TIMEOUT_CYCLES, 4096: RUN watchdog limit; used only with CPU_BOOT_DRIVER_TIMEOUT_EN.

Ports (one clock; reset is synchronous and active-high):
- clk, in, 1: system clock; all state changes on the rising edge.
- reset, in, 1: synchronous, active-high block reset.
- CPU_start, in, 1: level request; only its rising edge is acted on.
- init_data, in, 32*INIT_WORDS: flattened init words; word i is bits [32*i+31:32*i]; sampled at each WRITE cycle.
- MemWrite, in, 1: CPU store strobe.
- WriteData, in, 32: CPU store data.
- DataAdr, in, 32: CPU store address.
- cpu_reset, out, 1: core reset; 1 holds the CPU.
- Ext_MemWrite, out, 1: external memory write enable.
- Ext_WriteData, out, 32: external write data.
- Ext_DataAdr, out, 32: external write address.
- final_output, out, OUT_WIDTH: collected result bits.
- out_index, out, $clog2(OUT_WIDTH+1): number of bits collected so far.
- busy, out, 1: high in INIT_WR, INIT_GAP and RUN.
- done, out, 1: high in DONE.
- timeout, out, 1: watchdog expiry flag; constant 0 without the macro.

## Operation
- States: IDLE, INIT_WR, INIT_GAP, RUN, DONE. All outputs are registered.
- Reset values:
  - state=IDLE, cpu_reset=1.
  - Ext_MemWrite=0, Ext_WriteData=0, Ext_DataAdr=0.
  - final_output=0, out_index=0, busy=0, done=0, timeout=0.
  - Internal word counter=0, CPU_start history=0.
- Start edge: CPU_start=1 while the previous sampled value was 0.
  - Accepted in IDLE, RUN and DONE: clears final_output, out_index, done and timeout, sets word counter to 0, and goes to INIT_WR.
  - Ignored in INIT_WR and INIT_GAP.
  - A held-high CPU_start never retriggers.
- INIT_WR: cpu_reset=1, Ext_MemWrite=1, Ext_WriteData=word[k], Ext_DataAdr=INIT_BASE+k*ADR_STRIDE (32-bit wrap). Next state is INIT_GAP.
- INIT_GAP: Ext_MemWrite=0, Ext_WriteData=0, Ext_DataAdr=0.
  - If k==INIT_WORDS-1: go to RUN and drive cpu_reset=0.
  - Otherwise: k+1, back to INIT_WR.
- RUN: a capture event is MemWrite=1 and DataAdr==MAILBOX_ADR (exact 32-bit compare).
  - Each capture sets final_output[out_index]<=WriteData[0] and out_index+1.
  - The capture that fills bit OUT_WIDTH-1 moves to DONE, sets cpu_reset=1 and done=1.
  - CPU stores to other addresses are ignored. Stores while cpu_reset=1 are never captured.
- DONE: final_output holds until the next start edge or reset.
- reset asserted in any state, including mid-init, forces reset values on the next edge; a pending start edge in that cycle is discarded.

## Timing
- Start edge sampled at edge T: the first INIT_WR outputs are visible after edge T+1.
- Init occupies exactly 2*INIT_WORDS cycles. cpu_reset falls on the edge ending the last INIT_GAP.
- Capture latency: final_output and out_index update on the edge after the qualifying store cycle.
- done rises on the same edge as the final bit is written. Stores in that same cycle or later are ignored.
- Start edge coinciding with a capture in RUN: the start takes priority and the capture is dropped.

## Configuration
- CPU_BOOT_DRIVER_TIMEOUT_EN defined: RUN has a watchdog counter that clears on entry to RUN and on each capture.
  - When it reaches TIMEOUT_CYCLES with no capture, the block goes to DONE with timeout=1, done=1, cpu_reset=1.
  - Partial final_output is kept.
- Macro undefined: no counter is built, timeout is tied to 0, and RUN waits indefinitely.

## Test plan
- Reset then one CPU_start pulse, INIT_WORDS=2, init_data={32'hA5,32'h5A}:
  - Ext writes 32'h5A@02000000 and 32'hA5@02000004 on alternate cycles.
  - cpu_reset falls 4 cycles after the first write cycle begins.
- RUN, 8 mailbox stores with WriteData[0]=1,0,1,1,0,0,1,0:
  - final_output=8'h4D, out_index=8, done=1, cpu_reset=1.
- RUN, stores to 32'h02000004 and to the mailbox with MemWrite=0 -> final_output and out_index unchanged.
- Hold CPU_start high for 50 cycles -> exactly one init sequence. Drop and re-raise from DONE -> final_output cleared and init repeats.
- reset asserted during the second INIT_WR -> next cycle Ext_MemWrite=0, cpu_reset=1, state IDLE, busy=0.
- With the macro defined, TIMEOUT_CYCLES=16, 3 captures then silence:
  - timeout=1, done=1, out_index=3 exactly 16 cycles after the last capture.
  - Without the macro, the same stimulus keeps the block in RUN with timeout=0.
